// File: rtl/insn_queue_pkg.sv
// Shared fetch/decode types for the instruction queue.
package insn_queue_pkg;

    localparam int unsigned INSN_QUEUE_LG_DEPTH = 3;
    localparam int unsigned M_WIDTH             = 64;
    localparam int unsigned LG_PHT_SZ           = 12;
    localparam int unsigned INSN_W              = 32;
    localparam int unsigned FETCH_CYCLE_W       = 64;

    // One fetched instruction plus the metadata decode needs from fetch.
    // fetch_cycle is always carried; when cycle accounting is not used
    // downstream, synthesis prunes it.
    typedef struct packed {
        logic [INSN_W-1:0]        insn;
        logic [M_WIDTH-1:0]       pc;
        logic                     pred;
        logic [LG_PHT_SZ-1:0]     pht_idx;
        logic [M_WIDTH-1:0]       pred_target;
        logic [FETCH_CYCLE_W-1:0] fetch_cycle;
    } insn_queue_entry_t;

endpackage

// File: rtl/insn_queue_ptr.sv
// Head/tail pointers with wrap bit, full/empty/occupancy and flush/reset priority.
module insn_queue_ptr #(
    parameter int unsigned LG_DEPTH          = 3,
    parameter int unsigned ALMOST_FULL_SLACK = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                push_valid_i,
    input  logic                pop_ready_i,
    output logic                push_fire_o,
    output logic                push_ready_o,
    output logic [LG_DEPTH-1:0] head_idx_o,
    output logic [LG_DEPTH-1:0] tail_idx_o,
    output logic                empty_o,
    output logic [LG_DEPTH:0]   occupancy_o,
    output logic                almost_full_o
);

    localparam int unsigned PW    = LG_DEPTH + 1;
    localparam int unsigned DEPTH = 1 << LG_DEPTH;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic          full;
    logic          pop_fire;
    logic [PW-1:0] free_cnt;

    // Status derived purely from registered pointers (no push_valid -> push_ready path).
    always_comb begin
        empty_o       = (head_q == tail_q);
        full          = (head_q[PW-2:0] == tail_q[PW-2:0]) && (head_q[PW-1] != tail_q[PW-1]);
        occupancy_o   = tail_q - head_q;
        free_cnt      = PW'(DEPTH) - occupancy_o;
        almost_full_o = (free_cnt <= PW'(ALMOST_FULL_SLACK));
        push_ready_o  = !full;
        push_fire_o   = push_valid_i && !full;
        pop_fire      = pop_ready_i && !empty_o;
        head_idx_o    = head_q[PW-2:0];
        tail_idx_o    = tail_q[PW-2:0];
    end

    // Next pointers; flush overrides push and pop.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (push_fire_o) begin
            tail_d = tail_q + PW'(1);
        end
        if (pop_fire) begin
            head_d = head_q + PW'(1);
        end
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end
    end

    // Pointer registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

`ifndef SYNTHESIS
    a_occ_bound: assert property (@(posedge clk) disable iff (reset)
        occupancy_o <= PW'(DEPTH));
`endif

endmodule

// File: rtl/insn_queue.sv
// Fetch-to-decode instruction queue; head entry presented combinationally.
module insn_queue
    import insn_queue_pkg::*;
#(
    parameter int unsigned LG_DEPTH          = INSN_QUEUE_LG_DEPTH,
    parameter int unsigned ALMOST_FULL_SLACK = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [INSN_W-1:0]        push_insn,
    input  logic [M_WIDTH-1:0]       push_pc,
    input  logic                     push_pred,
    input  logic [LG_PHT_SZ-1:0]     push_pht_idx,
    input  logic [M_WIDTH-1:0]       push_pred_target,
    input  logic [FETCH_CYCLE_W-1:0] push_fetch_cycle,
    input  logic                     pop_ready,
    output logic                     out_valid,
    output logic [INSN_W-1:0]        out_insn,
    output logic [M_WIDTH-1:0]       out_pc,
    output logic                     out_pred,
    output logic [LG_PHT_SZ-1:0]     out_pht_idx,
    output logic [M_WIDTH-1:0]       out_pred_target,
    output logic [FETCH_CYCLE_W-1:0] out_fetch_cycle,
    output logic [LG_DEPTH:0]        occupancy,
    output logic                     almost_full,
    output logic                     empty
);

    localparam int unsigned DEPTH = 1 << LG_DEPTH;

    insn_queue_entry_t   mem_q [DEPTH];
    insn_queue_entry_t   push_entry;
    insn_queue_entry_t   head_entry;
    logic                push_fire;
    logic                wr_en;
    logic [LG_DEPTH-1:0] head_idx;
    logic [LG_DEPTH-1:0] tail_idx;

    insn_queue_ptr #(
        .LG_DEPTH          (LG_DEPTH),
        .ALMOST_FULL_SLACK (ALMOST_FULL_SLACK)
    ) u_ptr (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .push_valid_i  (push_valid),
        .pop_ready_i   (pop_ready),
        .push_fire_o   (push_fire),
        .push_ready_o  (push_ready),
        .head_idx_o    (head_idx),
        .tail_idx_o    (tail_idx),
        .empty_o       (empty),
        .occupancy_o   (occupancy),
        .almost_full_o (almost_full)
    );

    // Pack push fields and unpack the head entry onto the decode outputs.
    always_comb begin
        push_entry.insn        = push_insn;
        push_entry.pc          = push_pc;
        push_entry.pred        = push_pred;
        push_entry.pht_idx     = push_pht_idx;
        push_entry.pred_target = push_pred_target;
        push_entry.fetch_cycle = push_fetch_cycle;
        wr_en                  = push_fire && !flush && !reset;
        head_entry             = mem_q[head_idx];
        out_valid              = !empty;
        out_insn               = head_entry.insn;
        out_pc                 = head_entry.pc;
        out_pred               = head_entry.pred;
        out_pht_idx            = head_entry.pht_idx;
        out_pred_target        = head_entry.pred_target;
        out_fetch_cycle        = head_entry.fetch_cycle;
    end

    // Entry storage; intentionally not reset or cleared on flush.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[tail_idx] <= push_entry;
        end
    end

`ifndef SYNTHESIS
    a_push_hold: assert property (@(posedge clk) disable iff (reset || flush)
        (push_valid && !push_ready) |=> (push_valid && $stable(push_entry)));
`endif

endmodule

// File: tb/tb_insn_queue.sv
// Directed plus random stimulus for insn_queue against a queue-based reference model.
module tb_insn_queue;
    import insn_queue_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic                     clk;
    logic                     reset;
    logic                     flush;
    logic                     push_valid;
    logic                     push_ready;
    logic                     pop_ready;
    logic                     out_valid;
    logic [INSN_W-1:0]        out_insn;
    logic [M_WIDTH-1:0]       out_pc;
    logic                     out_pred;
    logic [LG_PHT_SZ-1:0]     out_pht_idx;
    logic [M_WIDTH-1:0]       out_pred_target;
    logic [FETCH_CYCLE_W-1:0] out_fetch_cycle;
    logic [3:0]               occupancy;
    logic                     almost_full;
    logic                     empty;

    insn_queue_entry_t cur;
    insn_queue_entry_t mq[$];
    bit                must_hold;
    int                errors;
    int                checks;

    insn_queue dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .push_valid       (push_valid),
        .push_ready       (push_ready),
        .push_insn        (cur.insn),
        .push_pc          (cur.pc),
        .push_pred        (cur.pred),
        .push_pht_idx     (cur.pht_idx),
        .push_pred_target (cur.pred_target),
        .push_fetch_cycle (cur.fetch_cycle),
        .pop_ready        (pop_ready),
        .out_valid        (out_valid),
        .out_insn         (out_insn),
        .out_pc           (out_pc),
        .out_pred         (out_pred),
        .out_pht_idx      (out_pht_idx),
        .out_pred_target  (out_pred_target),
        .out_fetch_cycle  (out_fetch_cycle),
        .occupancy        (occupancy),
        .almost_full      (almost_full),
        .empty            (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic insn_queue_entry_t rand_entry();
        insn_queue_entry_t e;
        e.insn        = $urandom;
        e.pc          = {$urandom, $urandom};
        e.pred        = 1'($urandom_range(0, 1));
        e.pht_idx     = 12'($urandom);
        e.pred_target = {$urandom, $urandom};
        e.fetch_cycle = {$urandom, $urandom};
        return e;
    endfunction

    // Compare every DUT output against the reference queue.
    task automatic check_all();
        int n;
        n = mq.size();
        chk("out_valid", 64'(out_valid), 64'(n != 0));
        chk("empty", 64'(empty), 64'(n == 0));
        chk("occupancy", 64'(occupancy), 64'(n));
        chk("push_ready", 64'(push_ready), 64'(n < DEPTH));
        chk("almost_full", 64'(almost_full), 64'((DEPTH - n) <= 2));
        if (n > 0) begin
            chk("out_insn", 64'(out_insn), 64'(mq[0].insn));
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_pred", 64'(out_pred), 64'(mq[0].pred));
            chk("out_pht_idx", 64'(out_pht_idx), 64'(mq[0].pht_idx));
            chk("out_pred_target", out_pred_target, mq[0].pred_target);
            chk("out_fetch_cycle", out_fetch_cycle, mq[0].fetch_cycle);
        end
    endtask

    // One clock: predict acceptance from the model, advance, then check.
    task automatic step();
        insn_queue_entry_t e;
        bit pf;
        bit pp;
        e         = cur;
        pf        = push_valid && (mq.size() < DEPTH);
        pp        = pop_ready && (mq.size() > 0);
        must_hold = push_valid && !(mq.size() < DEPTH);
        @(posedge clk);
        if (reset || flush) begin
            mq.delete();
        end else begin
            if (pp) void'(mq.pop_front());
            if (pf) mq.push_back(e);
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        insn_queue_entry_t e1;
        errors     = 0;
        checks     = 0;
        must_hold  = 1'b0;
        reset      = 1'b1;
        flush      = 1'b0;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        cur        = '0;

        // Reset values
        step();
        step();
        reset = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_push_ready", 64'(push_ready), 64'd1);
        chk("rst_almost_full", 64'(almost_full), 64'd0);

        // Single push visible next cycle
        e1.insn = 32'h00a00513; e1.pc = 64'h1000; e1.pred = 1'b0; e1.pht_idx = 12'd5;
        e1.pred_target = 64'h0; e1.fetch_cycle = 64'd1;
        cur = e1; push_valid = 1'b1; pop_ready = 1'b0;
        step();
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_insn", 64'(out_insn), 64'h00a00513);
        chk("t1_out_pc", out_pc, 64'h1000);
        chk("t1_out_pht_idx", 64'(out_pht_idx), 64'd5);
        chk("t1_occupancy", 64'(occupancy), 64'd1);

        // Fill to 8, then a ninth push is refused
        for (int i = 2; i <= 8; i++) begin
            cur = rand_entry();
            step();
            chk("t2_almost_full", 64'(almost_full), 64'(i >= 6));
        end
        chk("t2_occupancy_full", 64'(occupancy), 64'd8);
        chk("t2_push_ready_full", 64'(push_ready), 64'd0);
        cur = rand_entry();
        step();
        chk("t2_occupancy_9th", 64'(occupancy), 64'd8);

        // Full: pop and (held) push in same cycle -> push refused
        pop_ready = 1'b1;
        step();
        chk("t3_occupancy", 64'(occupancy), 64'd7);
        chk("t3_push_ready", 64'(push_ready), 64'd1);
        pop_ready = 1'b0;
        step();
        push_valid = 1'b0; pop_ready = 1'b1;
        repeat (8) step();
        chk("t3_drained", 64'(empty), 64'd1);

        // Streaming push+pop across pointer wrap
        cur = rand_entry(); cur.pc = 64'h2000; push_valid = 1'b1; pop_ready = 1'b1;
        step();
        chk("t4_pc0", out_pc, 64'h2000);
        for (int k = 1; k <= 20; k++) begin
            cur = rand_entry(); cur.pc = 64'h2000 + 64'(4 * k);
            step();
            chk("t4_out_pc", out_pc, 64'h2000 + 64'(4 * k));
            chk("t4_occupancy", 64'(occupancy), 64'd1);
        end

        // Flush with a same-cycle push at occupancy 5
        pop_ready = 1'b0;
        repeat (4) begin
            cur = rand_entry();
            step();
        end
        chk("t5_occ5", 64'(occupancy), 64'd5);
        flush = 1'b1; cur = rand_entry();
        step();
        flush = 1'b0; push_valid = 1'b0;
        chk("t5_empty", 64'(empty), 64'd1);
        chk("t5_occupancy", 64'(occupancy), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        e1 = rand_entry(); cur = e1; push_valid = 1'b1;
        step();
        push_valid = 1'b0;
        chk("t5_next_insn", 64'(out_insn), 64'(e1.insn));
        chk("t5_next_occ", 64'(occupancy), 64'd1);

        // Reset mid-stream with push and pop asserted
        push_valid = 1'b1;
        repeat (2) begin
            cur = rand_entry();
            step();
        end
        chk("t6_occ3", 64'(occupancy), 64'd3);
        reset = 1'b1; pop_ready = 1'b1; cur = rand_entry();
        step();
        reset = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
        chk("t6_empty", 64'(empty), 64'd1);
        chk("t6_occupancy", 64'(occupancy), 64'd0);
        chk("t6_push_ready", 64'(push_ready), 64'd1);
        chk("t6_almost_full", 64'(almost_full), 64'd0);

        // Random traffic with occasional flush and reset
        for (int c = 0; c < 1500; c++) begin
            reset     = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            pop_ready = ($urandom_range(0, 2) != 0);
            if (!must_hold) begin
                push_valid = ($urandom_range(0, 2) != 0);
                cur        = rand_entry();
            end
            step();
        end
        reset = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/insn_queue.md
Name: insn_queue

Overview:
- Circular buffer between the fetch stage and the RISC-V decode stage.
- Holds fetched instruction words together with their fetch-side metadata: pc, branch prediction, PHT index, predicted target and fetch cycle.
- Presents the oldest entry to decode combinationally, so the per-instruction decode logic can sit directly on its outputs.
- Absorbs fetch/decode rate mismatch; supports a pipeline flush on branch mispredict or exception restart.

Parameters:
- LG_DEPTH, 3, log2 of entry count (DEPTH = 8).
- ALMOST_FULL_SLACK, 2, almost_full asserts when free entries <= this value.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (mispredict/restart)
- push_valid  in  1  fetch presents an entry
- push_ready  out  1  queue can accept (= !full)
- push_insn  in  32  instruction word
- push_pc  in  `M_WIDTH  instruction pc
- push_pred  in  1  predicted-taken bit
- push_pht_idx  in  `LG_PHT_SZ  PHT index used for the prediction
- push_pred_target  in  `M_WIDTH  predicted target
- push_fetch_cycle  in  64  cycle counter at fetch
- pop_ready  in  1  decode consumes head this cycle
- out_valid  out  1  head entry valid (= !empty)
- out_insn, out_pc, out_pred, out_pht_idx, out_pred_target, out_fetch_cycle  out  (same widths as push_*)  head entry fields
- occupancy  out  LG_DEPTH+1  number of valid entries
- almost_full  out  1  fetch throttle hint
- empty  out  1  no valid entries

Behaviour:
- Storage and pointers:
  - Storage is a DEPTH-entry array of entry_t.
  - Head and tail pointers are LG_DEPTH+1 bits; the MSB is the wrap bit.
  - empty = (head == tail).
  - full = (low bits equal) && (wrap bits differ).
- Push:
  - Fires on push_valid && push_ready.
  - Writes array[tail] and increments tail (modulo 2^(LG_DEPTH+1)) on the next clk edge.
- Pop:
  - Fires on pop_ready && out_valid.
  - Increments head.
  - pop_ready while empty is ignored; no pointer change, no error.
- Ready/valid timing:
  - push_ready depends only on registered state, so push_valid has no combinational path to push_ready.
  - When full, push_ready = 0 even if pop fires in the same cycle (no full-bypass).
- Output path:
  - out_* are a combinational read of array[head]; zero latency from head update.
  - An entry pushed in cycle N is visible on out_* in cycle N+1 (no empty-bypass).
  - When empty, out_* fields carry the stale array[head] value; consumers qualify them with out_valid.
- Simultaneous push and pop when neither empty nor full: both pointers advance and occupancy is unchanged.
- Derived outputs:
  - occupancy = tail - head (LG_DEPTH+1 bit subtraction, wrap-safe); range 0..DEPTH.
  - almost_full = (DEPTH - occupancy) <= ALMOST_FULL_SLACK.
- Flush:
  - Sets head = tail = 0 on the next edge.
  - Has priority over a same-cycle push and pop; the pushed entry is dropped and the pop is a don't-care.
  - Array contents are not cleared.
  - out_valid = 0 in the cycle after flush.
- Reset:
  - Same pointer effect as flush; reset has priority over flush, push and pop.
  - Output values after reset: out_valid = 0, empty = 1, occupancy = 0, push_ready = 1, almost_full = 0.
  - Reset asserted mid-stream discards all entries; the array is not reset.
- Wrap-around: pointer low bits wrap from DEPTH-1 to 0 and the wrap bit toggles; no dead entries at the boundary.
- Assertions (simulation only):
  - push_valid with all push_* stable while !push_ready.
  - occupancy never exceeds DEPTH.

Decomposition:
- Shared package (alongside the uop definitions):
  - typedef insn_queue_entry_t {insn, pc, pred, pht_idx, pred_target, fetch_cycle};
  - localparam INSN_QUEUE_LG_DEPTH.
- fetch_cycle is kept in entry_t unconditionally; under ENABLE_CYCLE_ACCOUNTING it feeds decode, otherwise it is left for synthesis to prune.
- One natural sub-module, insn_queue_ptr, holds the head/tail registers, full/empty/occupancy logic and flush/reset priority. Data storage stays in insn_queue.

Test Plan:
- Reset then single push (insn=32'h00a00513, pc=0x1000, pred=0, pht_idx=5, pop_ready=0) -> cycle+1: out_valid=1, out_insn=32'h00a00513, out_pc=0x1000, out_pht_idx=5, occupancy=1.
- Push 8 entries with pop_ready=0 -> occupancy=8, push_ready=0, almost_full=1 from occupancy 6 onward; 9th push_valid is not accepted and occupancy stays 8.
- Full, then pop_ready=1 and push_valid=1 for one cycle -> head advances, push not accepted; next cycle occupancy=7, push_ready=1.
- Steady push+pop for 20 cycles with pc incrementing by 4 from 0x2000 -> out_pc sequence 0x2000,0x2004,... with no gaps or duplicates across pointer wrap; occupancy constant at 1.
- Occupancy=5, assert flush with push_valid=1 in the same cycle -> cycle+1: empty=1, occupancy=0, out_valid=0, pushed entry absent; the next push appears at out_*.
- Occupancy=3, assert reset together with push_valid and pop_ready -> cycle+1: empty=1, occupancy=0, push_ready=1, almost_full=0.
